gpr_regfile: RTL and testbench
==============================

Name: gpr_regfile

Overview:
- General-purpose register file at the far end of the MEM/WB writeback interface; consumes wb_gpr_we/waddr/wdata from the MEM/WB stage register.
- Serves two ID-stage read ports (rs, rt) plus one debug read port.
- Write-to-read bypass in the same cycle closes the WB→ID hazard.
- Keeps a committed-write counter for performance/debug.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; must equal $clog2(NUM_REGS).
- DATA_W, 32, register data width; matches word_t.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wb_gpr_we  input  1  writeback enable from MEM/WB.
- wb_gpr_waddr  input  ADDR_W  writeback destination register.
- wb_gpr_wdata  input  DATA_W  writeback data.
- rs_raddr  input  ADDR_W  read port A address (ID stage).
- rs_rdata  output  DATA_W  read port A data.
- rt_raddr  input  ADDR_W  read port B address (ID stage).
- rt_rdata  output  DATA_W  read port B data.
- dbg_raddr  input  ADDR_W  debug read address.
- dbg_rdata  output  DATA_W  debug read data (no bypass).
- wr_count  output  CNT_W  number of committed writes to registers 1..NUM_REGS-1.

Behaviour:
- Reset: on a posedge with rst=1, all registers are cleared to 0 and wr_count is cleared to 0. A write presented in the same cycle is dropped.
- While rst=1, rs_rdata, rt_rdata and dbg_rdata are forced to 0.
- Write: on a posedge with rst=0, wb_gpr_we=1 and wb_gpr_waddr!=0, the register at waddr takes wdata and wr_count increments by 1.
  - Write latency is 1 cycle: the stored value is visible on dbg_rdata in the next cycle.
  - Writes to register 0 are discarded and do not increment wr_count.
- wr_count wraps modulo 2^CNT_W; there is no saturation.
- Read ports rs/rt are combinational from the address inputs, with priority:
  - address == 0 → 0;
  - otherwise, wb_gpr_we=1 and wb_gpr_waddr == raddr → wb_gpr_wdata (bypass);
  - otherwise → the stored register.
- Both read ports may hit the same address, and both may bypass in the same cycle; each port resolves independently.
- dbg_rdata is the stored value only, with no bypass; address 0 returns 0.
- A pipeline flush is signalled upstream by MEM/WB driving we=0 and waddr=0. The regfile treats this as a no-op and holds no flush input.
- Stalls are not visible to this block: MEM/WB holds its outputs, so a held write re-commits the same value each cycle. wr_count then counts every cycle in which we=1 and waddr!=0; this is a decided property, not a bug.
- Unknown or X addresses are not guarded; the bench drives legal values only.

Decomposition:
- bit_t, word_t and regaddr_t come from the shared defines package already used by the pipeline.
- Add the constants GPR_NUM=32 and GPR_ZERO='0 to that package. Parameter defaults derive from these constants.
- A sub-module gpr_read_port (address, write-port snoop, storage array slice → data) implements the zero/bypass/stored priority. It is instantiated twice (rs, rt).
- Storage, write logic and the counter live in the top module.

Test Plan:
- Reset with we=1, waddr=5, wdata=32'hDEAD held during rst → after reset, dbg read of r5 = 0, wr_count = 0, all read ports read 0 during rst.
- Write r3=32'h1234_5678 in cycle N, with rs_raddr=3 in the same cycle → rs_rdata = 32'h1234_5678 in cycle N (bypass); at N+1 with we=0, rs_rdata and dbg_rdata = 32'h1234_5678; wr_count = 1.
- Write r0=32'hFFFF_FFFF → rs/rt/dbg reading address 0 return 0 in the same and the next cycle; wr_count unchanged.
- rs_raddr=rt_raddr=7 while writing r7=32'hA5A5_A5A5 → both ports return 32'hA5A5_A5A5 in that cycle; dbg_rdata still returns the old r7 until the next cycle.
- Back-to-back writes r9=1, r9=2, r9=3 over 3 cycles → r9 reads 3; wr_count +3. Then hold we=1, r9=3 for 4 more cycles → wr_count +4, value unchanged.
- Mid-operation reset after r1..r31 are written with values i*16 → one rst cycle clears all 31 registers to 0 and wr_count to 0; a write in the first cycle after reset commits normally.

Source files
------------

// File: rtl/gpr_regfile_pkg.sv
// Shared pipeline types plus the general-purpose register file constants.
// Register 0 is architecturally hardwired to zero.
package gpr_regfile_pkg;

  typedef logic        bit_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  localparam int       GPR_NUM  = 32;
  localparam regaddr_t GPR_ZERO = '0;

endpackage

// File: rtl/gpr_read_port.sv
// One ID-stage read port: resolves zero register, writeback bypass, then stored value.
module gpr_read_port
  import gpr_regfile_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM,
  parameter int ADDR_W   = $clog2(GPR_NUM),
  parameter int DATA_W   = $bits(word_t)
) (
  input  logic                       i_rst,
  input  logic [ADDR_W-1:0]          i_raddr,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_waddr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] i_regs_flat,
  output logic [DATA_W-1:0]          o_rdata
);

  logic w_is_zero;
  logic w_bypass;

  assign w_is_zero = (i_raddr == ADDR_W'(GPR_ZERO));
  assign w_bypass  = i_we && (i_waddr == i_raddr);

  // A write to r0 can never bypass because the zero check wins first.
  always_comb begin
    o_rdata = '0;
    if (i_rst || w_is_zero) begin
      o_rdata = '0;
    end else if (w_bypass) begin
      o_rdata = i_wdata;
    end else begin
      o_rdata = i_regs_flat[int'(i_raddr)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/gpr_regfile.sv
// General-purpose register file fed by the MEM/WB writeback port, with two
// bypassing ID read ports, a non-bypassing debug port and a committed-write counter.
module gpr_regfile
  import gpr_regfile_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM,
  parameter int ADDR_W   = $clog2(GPR_NUM),
  parameter int DATA_W   = $bits(word_t),
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_gpr_we,
  input  logic [ADDR_W-1:0] wb_gpr_waddr,
  input  logic [DATA_W-1:0] wb_gpr_wdata,
  input  logic [ADDR_W-1:0] rs_raddr,
  output logic [DATA_W-1:0] rs_rdata,
  input  logic [ADDR_W-1:0] rt_raddr,
  output logic [DATA_W-1:0] rt_rdata,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [CNT_W-1:0]           r_wr_count;
  logic                       w_commit;
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  logic [DATA_W-1:0]          w_dbg_rdata;

  // Flush (we=0, waddr=0) and r0 writes both fall out of this term.
  assign w_commit = wb_gpr_we && (wb_gpr_waddr != ADDR_W'(GPR_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_regs[wb_gpr_waddr] <= wb_gpr_wdata;
      r_wr_count           <= r_wr_count + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  gpr_read_port #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_rs_port (
    .i_rst       (rst),
    .i_raddr     (rs_raddr),
    .i_we        (wb_gpr_we),
    .i_waddr     (wb_gpr_waddr),
    .i_wdata     (wb_gpr_wdata),
    .i_regs_flat (w_regs_flat),
    .o_rdata     (rs_rdata)
  );

  gpr_read_port #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_rt_port (
    .i_rst       (rst),
    .i_raddr     (rt_raddr),
    .i_we        (wb_gpr_we),
    .i_waddr     (wb_gpr_waddr),
    .i_wdata     (wb_gpr_wdata),
    .i_regs_flat (w_regs_flat),
    .o_rdata     (rt_rdata)
  );

  // Debug port shows committed state only, so it lags a write by one cycle.
  always_comb begin
    w_dbg_rdata = '0;
    if (!rst && (dbg_raddr != ADDR_W'(GPR_ZERO))) begin
      w_dbg_rdata = r_regs[dbg_raddr];
    end
  end

  assign dbg_rdata = w_dbg_rdata;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_gpr_regfile.sv
// Directed bench for gpr_regfile: reset, bypass, r0, dual-port, held writes, mid-run reset.
module tb_gpr_regfile;

  logic        clk;
  logic        rst;
  logic        wb_gpr_we;
  logic [4:0]  wb_gpr_waddr;
  logic [31:0] wb_gpr_wdata;
  logic [4:0]  rs_raddr;
  logic [31:0] rs_rdata;
  logic [4:0]  rt_raddr;
  logic [31:0] rt_rdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] wr_count;

  int n_checks;
  int n_errors;

  gpr_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_gpr_we    (wb_gpr_we),
    .wb_gpr_waddr (wb_gpr_waddr),
    .wb_gpr_wdata (wb_gpr_wdata),
    .rs_raddr     (rs_raddr),
    .rs_rdata     (rs_rdata),
    .rt_raddr     (rt_raddr),
    .rt_rdata     (rt_rdata),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, checks run #2 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd5; wb_gpr_wdata = 32'hDEAD;
    rs_raddr = 5'd5; rt_raddr = 5'd5; dbg_raddr = 5'd5;
    #2;
    n_checks++;
    if (rs_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rs_during_rst got %h want %h", rs_rdata, 32'h0); end
    n_checks++;
    if (rt_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rt_during_rst got %h want %h", rt_rdata, 32'h0); end
    step(); step(); step();
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_dbg_during_rst got %h want %h", dbg_rdata, 32'h0); end
    rst = 1'b0; wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_r5_cleared got %h want %h", dbg_rdata, 32'h0); end
    n_checks++;
    if (wr_count !== 32'd0) begin n_errors++; $display("FAIL reset_wr_count got %0d want %0d", wr_count, 0); end
  endtask

  task automatic test_write_bypass();
    step();
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd3; wb_gpr_wdata = 32'h1234_5678;
    rs_raddr = 5'd3; rt_raddr = 5'd5; dbg_raddr = 5'd3;
    #2;
    n_checks++;
    if (rs_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL bypass_rs_same_cycle got %h want %h", rs_rdata, 32'h1234_5678); end
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL bypass_dbg_no_bypass got %h want %h", dbg_rdata, 32'h0); end
    step();
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (rs_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL write_rs_stored got %h want %h", rs_rdata, 32'h1234_5678); end
    n_checks++;
    if (dbg_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL write_dbg_stored got %h want %h", dbg_rdata, 32'h1234_5678); end
    n_checks++;
    if (wr_count !== 32'd1) begin n_errors++; $display("FAIL write_wr_count got %0d want %0d", wr_count, 1); end
  endtask

  task automatic test_zero_reg();
    step();
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'hFFFF_FFFF;
    rs_raddr = 5'd0; rt_raddr = 5'd0; dbg_raddr = 5'd0;
    #2;
    n_checks++;
    if (rs_rdata !== 32'h0) begin n_errors++; $display("FAIL zero_rs_same got %h want %h", rs_rdata, 32'h0); end
    n_checks++;
    if (rt_rdata !== 32'h0) begin n_errors++; $display("FAIL zero_rt_same got %h want %h", rt_rdata, 32'h0); end
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL zero_dbg_same got %h want %h", dbg_rdata, 32'h0); end
    step();
    wb_gpr_we = 1'b0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (rs_rdata !== 32'h0) begin n_errors++; $display("FAIL zero_rs_next got %h want %h", rs_rdata, 32'h0); end
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL zero_dbg_next got %h want %h", dbg_rdata, 32'h0); end
    n_checks++;
    if (wr_count !== 32'd1) begin n_errors++; $display("FAIL zero_wr_count got %0d want %0d", wr_count, 1); end
  endtask

  task automatic test_dual_port();
    step();
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd7; wb_gpr_wdata = 32'hA5A5_A5A5;
    rs_raddr = 5'd7; rt_raddr = 5'd7; dbg_raddr = 5'd7;
    #2;
    n_checks++;
    if (rs_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL dual_rs_bypass got %h want %h", rs_rdata, 32'hA5A5_A5A5); end
    n_checks++;
    if (rt_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL dual_rt_bypass got %h want %h", rt_rdata, 32'hA5A5_A5A5); end
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL dual_dbg_old got %h want %h", dbg_rdata, 32'h0); end
    step();
    // Write r9 while rs reads stored r3 and rt bypasses r9.
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd9; wb_gpr_wdata = 32'h0000_00C3;
    rs_raddr = 5'd3; rt_raddr = 5'd9;
    #2;
    n_checks++;
    if (dbg_rdata !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL dual_dbg_new got %h want %h", dbg_rdata, 32'hA5A5_A5A5); end
    n_checks++;
    if (rs_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL split_rs_stored got %h want %h", rs_rdata, 32'h1234_5678); end
    n_checks++;
    if (rt_rdata !== 32'h0000_00C3) begin n_errors++; $display("FAIL split_rt_bypass got %h want %h", rt_rdata, 32'h0000_00C3); end
    step();
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (wr_count !== 32'd3) begin n_errors++; $display("FAIL dual_wr_count got %0d want %0d", wr_count, 3); end
  endtask

  task automatic test_back_to_back();
    step();
    rs_raddr = 5'd9; rt_raddr = 5'd0; dbg_raddr = 5'd9;
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd9; wb_gpr_wdata = 32'd1;
    step();
    wb_gpr_wdata = 32'd2;
    #2;
    n_checks++;
    if (dbg_rdata !== 32'd1) begin n_errors++; $display("FAIL b2b_dbg_lag got %0d want %0d", dbg_rdata, 1); end
    n_checks++;
    if (rs_rdata !== 32'd2) begin n_errors++; $display("FAIL b2b_rs_bypass got %0d want %0d", rs_rdata, 2); end
    step();
    wb_gpr_wdata = 32'd3;
    step();
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (rs_rdata !== 32'd3) begin n_errors++; $display("FAIL b2b_r9_value got %0d want %0d", rs_rdata, 3); end
    n_checks++;
    if (wr_count !== 32'd6) begin n_errors++; $display("FAIL b2b_wr_count got %0d want %0d", wr_count, 6); end
    wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd9; wb_gpr_wdata = 32'd3;
    for (int k = 0; k < 4; k++) step();
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    #2;
    n_checks++;
    if (wr_count !== 32'd10) begin n_errors++; $display("FAIL held_wr_count got %0d want %0d", wr_count, 10); end
    n_checks++;
    if (dbg_rdata !== 32'd3) begin n_errors++; $display("FAIL held_r9_value got %0d want %0d", dbg_rdata, 3); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    step();
    for (int i = 1; i < 32; i++) begin
      wb_gpr_we = 1'b1; wb_gpr_waddr = 5'(i); wb_gpr_wdata = 32'(i * 16);
      step();
    end
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    dbg_raddr = 5'd31; rs_raddr = 5'd1;
    #2;
    n_checks++;
    if (dbg_rdata !== 32'h1F0) begin n_errors++; $display("FAIL fill_r31 got %h want %h", dbg_rdata, 32'h1F0); end
    n_checks++;
    if (rs_rdata !== 32'h10) begin n_errors++; $display("FAIL fill_r1 got %h want %h", rs_rdata, 32'h10); end
    n_checks++;
    if (wr_count !== 32'd41) begin n_errors++; $display("FAIL fill_wr_count got %0d want %0d", wr_count, 41); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; wb_gpr_we = 1'b1; wb_gpr_waddr = 5'd4; wb_gpr_wdata = 32'hBEEF;
    dbg_raddr = 5'd31;
    #2;
    n_checks++;
    if (wr_count !== 32'd0) begin n_errors++; $display("FAIL midrst_wr_count got %0d want %0d", wr_count, 0); end
    n_checks++;
    if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL midrst_r31 got %h want %h", dbg_rdata, 32'h0); end
    step();
    wb_gpr_we = 1'b0; wb_gpr_waddr = 5'd0; wb_gpr_wdata = 32'h0;
    for (int i = 1; i < 32; i++) begin
      dbg_raddr = 5'(i);
      exp = (i == 4) ? 32'hBEEF : 32'h0;
      #1;
      n_checks++;
      if (dbg_rdata !== exp) begin n_errors++; $display("FAIL midrst_reg r%0d got %h want %h", i, dbg_rdata, exp); end
    end
    n_checks++;
    if (wr_count !== 32'd1) begin n_errors++; $display("FAIL post_rst_wr_count got %0d want %0d", wr_count, 1); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_dual_port();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
